ysyx_23060077_axi_mem_slave: RTL and testbench
==============================================

Name: ysyx_23060077_axi_mem_slave

Overview:
AXI4 responder: the slave end of the core's 64-bit AXI master port, backed by an internal byte-writable memory array.
- Used as the standalone memory model on the bench.
- Also the target for the top level's io_slave channel set.
- Serves one transaction at a time (read or write) with INCR/FIXED bursts and a programmable read latency.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (byte lanes = DATA_WIDTH/8)
ID_WIDTH, 4, AXI ID width
MEM_WORDS, 4096, memory depth in DATA_WIDTH words
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LAT, 1, cycles from AR handshake to first R beat (0 = next cycle)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
awready/awvalid  out/in  1  write-address handshake
awaddr/awid/awlen/awsize/awburst  in  32/4/8/3/2  write-address payload
wready/wvalid  out/in  1  write-data handshake
wdata/wstrb/wlast  in  64/8/1  write-data payload
bready/bvalid  in/out  1  write-response handshake
bresp/bid  out  2/4  write response
arready/arvalid  out/in  1  read-address handshake
araddr/arid/arlen/arsize/arburst  in  32/4/8/3/2  read-address payload
rready/rvalid  in/out  1  read-data handshake
rresp/rdata/rlast/rid  out  2/64/1/4  read data

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous and active-high.
- Reset state:
  - FSM in IDLE; rr bit = 0 (read favoured).
  - All valid/ready outputs = 0; rdata = 0; rresp = bresp = 0; rid = bid = 0; rlast = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the transaction silently; beats already written persist.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE arbitration:
  - Only arvalid: grant read. Only awvalid: grant write.
  - Both valid: grant per rr bit; rr toggles after every grant.
  - arready = IDLE & read granted; awready = IDLE & write granted. Both are combinational from the valids and never high together.
- AR handshake:
  - Latch id, addr, len, size, burst.
  - Beat counter = 0; latency counter = RD_LAT.
  - Go to RD_WAIT, or straight to RD_DATA when RD_LAT = 0.
- RD_WAIT: decrement latency counter; enter RD_DATA when it reaches 0.
- RD_DATA:
  - rvalid = 1.
  - rdata = mem[word index of current addr], full word (narrow transfers use natural lanes).
  - rid = latched id; rlast = (beat == len).
  - Payload holds stable while rready = 0.
  - On rvalid & rready: advance address and beat. After the last beat, return to IDLE; the next ready is asserted at the earliest one cycle later.
- AW handshake: latch payload; go to WR_DATA.
- WR_DATA:
  - wready = 1.
  - Each wvalid & wready beat writes the wstrb-enabled bytes of wdata to the current word.
  - Beat counter advances; after beat len, go to WR_RESP.
  - wlast mismatch (asserted before beat len, or absent at beat len) sets the error flag. Beat count alone terminates the burst.
- WR_RESP:
  - bvalid = 1, bid = latched id.
  - bresp = OKAY (2'b00), or SLVERR (2'b10) if the error flag is set.
  - Held until bready, then IDLE.
- Address rules:
  - Word index = (addr − BASE_ADDR) >> 3.
  - INCR: addr += 1 << size per beat. FIXED: addr constant. No 4KB-boundary check.
  - The whole burst is SLVERR if any of the following hold: the first addr is outside [BASE_ADDR, BASE_ADDR + 8·MEM_WORDS); size > 3; burst is WRAP or reserved (2'b11).
  - A beat that runs out of range mid-INCR is SLVERR for that beat.
  - Erroring read beats return rdata = 0.
  - Erroring write beats do not modify memory; bresp = SLVERR.
- Handshake rules: valid never depends on ready; once asserted, valid stays high until the handshake completes.
- A len of 255 (256 beats) must work; beat counter is 8 bits and wraps only after completion.

Decomposition:
- Shared package: burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/EXOKAY/SLVERR/DECERR), FSM state enum. Place these alongside the existing AXI width defines.
- One sub-module, ysyx_23060077_sram_bwe:
  - Single-port MEM_WORDS × DATA_WIDTH array.
  - Per-byte write enable.
  - Combinational read.
  - One port is sufficient because the FSM serialises all transactions.

Test Plan:
1. Single write then read: AW addr 0x8000_0010, len 0, size 3, wdata 0x1122334455667788, wstrb 0xFF → bresp 0. AR same addr → rdata 0x1122334455667788, rlast 1, rresp 0, first rvalid RD_LAT+1 cycles after the AR handshake.
2. INCR burst: write len 3 at 0x8000_0100 with data 0..3 (id 5) → bid 5. Read back len 3 with rready toggling 1/0 each cycle → beats 0,1,2,3 in order; payload stable during stalls; rlast only on beat 3; rid 5.
3. Byte strobes: preload 0xFFFF_FFFF_FFFF_FFFF; write wdata 0, wstrb 0x0F → readback 0xFFFF_FFFF_0000_0000.
4. Arbitration: arvalid and awvalid both raised in the same cycle out of reset → read granted first (arready=1, awready=0); the write is granted after the read completes; the next simultaneous pair grants the write first.
5. Errors:
   - AR at 0x0000_0000 → rresp 2'b10, rdata 0.
   - AW burst WRAP → bresp 2'b10, memory unchanged.
   - INCR write len 1 with wlast on beat 0 → bresp 2'b10 after 2 beats.
6. Reset mid-burst: assert reset during beat 2 of a len-7 read → next cycle rvalid=0, arready=0. After release, a new single read completes normally.

Source files
------------

// File: rtl/ysyx_23060077_axi_mem_slave_pkg.sv
// Shared AXI widths, burst/response encodings and the memory-slave FSM state type.
package ysyx_23060077_axi_mem_slave_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 4;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdData,
        StWrData,
        StWrResp
    } state_e;

endpackage

// File: rtl/ysyx_23060077_sram_bwe.sv
// Single-port word array with per-byte write enables and a combinational read port.
module ysyx_23060077_sram_bwe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS  = 4096
) (
    input  logic                         clock,
    input  logic [DATA_WIDTH/8-1:0]      we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ysyx_23060077_axi_mem_slave.sv
// AXI4 slave memory model: serves one read or write burst at a time from a byte-writable array.
module ysyx_23060077_axi_mem_slave
    import ysyx_23060077_axi_mem_slave_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = AXI_ADDR_W,
    parameter int unsigned           DATA_WIDTH = AXI_DATA_W,
    parameter int unsigned           ID_WIDTH   = AXI_ID_W,
    parameter int unsigned           MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned           RD_LAT     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    awready,
    input  logic                    awvalid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    output logic                    wready,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    bready,
    output logic                    bvalid,
    output logic [1:0]              bresp,
    output logic [ID_WIDTH-1:0]     bid,
    output logic                    arready,
    input  logic                    arvalid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    rready,
    output logic                    rvalid,
    output logic [1:0]              rresp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rlast,
    output logic [ID_WIDTH-1:0]     rid
);

    localparam int unsigned           STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned           BYTE_SHIFT = $clog2(STRB_W);
    localparam int unsigned           IDX_W      = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(MEM_WORDS * STRB_W);
    localparam state_e                RD_FIRST   = (RD_LAT == 0) ? StRdData : StRdWait;

    state_e                  state_q, state_d;
    logic                    rr_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q, beat_q, lat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    bad_q, werr_q;

    logic                    grant_rd, grant_wr, ar_hs, aw_hs, r_hs, w_hs, last, beat_err;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [IDX_W-1:0]        word_idx;
    logic [STRB_W-1:0]       mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    // Whole-burst errors are decided once, from the first address and the burst attributes.
    function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                       input logic [1:0] burst);
        return !in_range(a) || (32'(size) > BYTE_SHIFT) ||
               !(burst == BurstFixed || burst == BurstIncr);
    endfunction

    always_comb begin
        grant_rd  = arvalid && (!awvalid || !rr_q);
        grant_wr  = awvalid && (!arvalid || rr_q);
        ar_hs     = arvalid && arready;
        aw_hs     = awvalid && awready;
        r_hs      = rvalid && rready;
        w_hs      = wvalid && wready;
        last      = (beat_q == len_q);
        beat_err  = bad_q || !in_range(addr_q);
        next_addr = (burst_q == BurstIncr) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
        word_idx  = IDX_W'((addr_q - BASE_ADDR) >> BYTE_SHIFT);
        mem_we    = (w_hs && !beat_err) ? wstrb : '0;
    end

    ysyx_23060077_sram_bwe #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .clock(clock),
        .we   (mem_we),
        .addr (word_idx),
        .wdata(wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d = RD_FIRST;
                end else if (aw_hs) begin
                    state_d = StWrData;
                end
            end
            StRdWait: if (lat_q <= 8'd1) state_d = StRdData;
            StRdData: if (r_hs && last) state_d = StIdle;
            StWrData: if (w_hs && last) state_d = StWrResp;
            StWrResp: if (bready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = RespOkay;
        bid     = '0;
        rvalid  = 1'b0;
        rresp   = RespOkay;
        rdata   = '0;
        rlast   = 1'b0;
        rid     = '0;
        unique case (state_q)
            StIdle: begin
                arready = grant_rd && !reset;
                awready = grant_wr && !reset;
            end
            StRdData: begin
                rvalid = 1'b1;
                rid    = id_q;
                rlast  = last;
                rresp  = beat_err ? RespSlverr : RespOkay;
                rdata  = beat_err ? '0 : mem_rdata;
            end
            StWrData: wready = 1'b1;
            StWrResp: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = (bad_q || werr_q) ? RespSlverr : RespOkay;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q    <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            bad_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            if (ar_hs || aw_hs) begin
                rr_q    <= ~rr_q;
                beat_q  <= '0;
                werr_q  <= 1'b0;
                lat_q   <= 8'(RD_LAT);
                id_q    <= ar_hs ? arid : awid;
                addr_q  <= ar_hs ? araddr : awaddr;
                len_q   <= ar_hs ? arlen : awlen;
                size_q  <= ar_hs ? arsize : awsize;
                burst_q <= ar_hs ? arburst : awburst;
                bad_q   <= ar_hs ? burst_bad(araddr, arsize, arburst)
                                 : burst_bad(awaddr, awsize, awburst);
            end
            if (state_q == StRdWait) begin
                lat_q <= lat_q - 8'd1;
            end
            if (r_hs || w_hs) begin
                addr_q <= next_addr;
                beat_q <= beat_q + 8'd1;
            end
            // Beat count ends the burst; a misplaced wlast only poisons the response.
            if (w_hs && ((wlast != last) || beat_err)) begin
                werr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_axi_mem_slave.sv
// Directed bench for the AXI memory slave: hand-computed vectors, one checking task.
module tb_ysyx_23060077_axi_mem_slave;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam int         LAT_EXP = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic        arready, arvalid, rready, rvalid, rlast;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic [63:0] wbuf      [256];
    logic [63:0] rexp      [256];
    logic [1:0]  rexp_resp [256];

    always #5 clock = ~clock;

    ysyx_23060077_axi_mem_slave #(.RD_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast),
        .rid(rid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awid = id; awvalid = 1'b1;
        #1;
        while (!awready && n < 100) begin @(posedge clock); #1; n++; end
        if (!awready) chk("aw_timeout", awready, 1);
        @(posedge clock); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [7:0] strb, input int last_at,
                           output logic [1:0] resp, output logic [3:0] bid_o);
        int n;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
            wlast = (last_at < 0) ? (b == int'(len)) : (b == last_at);
            n = 0;
            while (!wready && n < 100) begin @(posedge clock); #1; n++; end
            if (!wready) chk("w_timeout", wready, 1);
            @(posedge clock); #1;
        end
        wvalid = 0; wlast = 0; wstrb = 0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge clock); #1; n++; end
        if (!bvalid) chk("b_timeout", bvalid, 1);
        resp = bresp; bid_o = bid;
        @(posedge clock); #1;
        bready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id, input logic [7:0] strb,
                            input int last_at, input logic [1:0] exp_resp);
        logic [1:0] resp;
        logic [3:0] bid_o;
        aw_send(addr, len, burst, id);
        w_phase(len, strb, last_at, resp, bid_o);
        chk({tag, "_bresp"}, resp, exp_resp);
        chk({tag, "_bid"}, bid_o, id);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int n = 0;
        araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arid = id; arvalid = 1'b1;
        #1;
        while (!arready && n < 100) begin @(posedge clock); #1; n++; end
        if (!arready) chk("ar_timeout", arready, 1);
        @(posedge clock); #1;
        arvalid = 1'b0;
    endtask

    // Every cycle with rvalid high, stalled or not, must show the expected payload.
    task automatic r_recv(input logic [7:0] len, input logic [3:0] id, input bit toggle,
                          output int lat_o);
        int b = 0;
        int cyc = 0;
        lat_o = 1;
        while (!rvalid && lat_o < 100) begin @(posedge clock); #1; lat_o++; end
        if (!rvalid) chk("r_timeout", rvalid, 1);
        while (b <= int'(len) && cyc < 2000) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (rvalid) begin
                chk($sformatf("rdata[%0d]", b), rdata, rexp[b]);
                chk($sformatf("rresp[%0d]", b), rresp, rexp_resp[b]);
                chk($sformatf("rlast[%0d]", b), rlast, (b == int'(len)));
                chk($sformatf("rid[%0d]", b), rid, id);
                if (rready) b++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        rready = 1'b0;
        if (b <= int'(len)) chk("r_beats", b, int'(len) + 1);
        chk("r_done_rvalid", rvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input bit toggle);
        ar_send(addr, len, burst, id);
        r_recv(len, id, toggle, lat);
    endtask

    task automatic set_exp(input int idx, input logic [63:0] d, input logic [1:0] r);
        rexp[idx] = d;
        rexp_resp[idx] = r;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_dut();
        chk("rst_ready_valid", {arready, awready, wready, rvalid, bvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp_id_last", {rresp, bresp, rid, bid, rlast}, 0);
        reset = 1'b0;

        // Single write then read, with first-beat latency
        wbuf[0] = 64'h1122_3344_5566_7788;
        do_write("single", 32'h8000_0010, 0, INCR, 4'd1, 8'hFF, -1, 2'b00);
        set_exp(0, 64'h1122_3344_5566_7788, 2'b00);
        ar_send(32'h8000_0010, 0, INCR, 4'd1);
        r_recv(0, 4'd1, 1'b0, lat);
        chk("single_latency", lat, LAT_EXP);

        // INCR burst, read back with rready toggling
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i); set_exp(i, 64'(i), 2'b00); end
        do_write("incr", 32'h8000_0100, 3, INCR, 4'd5, 8'hFF, -1, 2'b00);
        do_read(32'h8000_0100, 3, INCR, 4'd5, 1'b1);

        // Byte strobes
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write("strb_pre", 32'h8000_0200, 0, INCR, 4'd2, 8'hFF, -1, 2'b00);
        wbuf[0] = 64'h0;
        do_write("strb", 32'h8000_0200, 0, INCR, 4'd2, 8'h0F, -1, 2'b00);
        set_exp(0, 64'hFFFF_FFFF_0000_0000, 2'b00);
        do_read(32'h8000_0200, 0, INCR, 4'd2, 1'b0);

        // FIXED burst keeps hitting the same word
        wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC;
        do_write("fixed", 32'h8000_0400, 2, FIXED, 4'd3, 8'hFF, -1, 2'b00);
        for (int i = 0; i < 3; i++) set_exp(i, 64'hC, 2'b00);
        do_read(32'h8000_0400, 2, FIXED, 4'd3, 1'b0);

        // Error responses
        set_exp(0, 64'h0, 2'b10);
        do_read(32'h0000_0000, 0, INCR, 4'd6, 1'b0);
        wbuf[0] = 64'hDEAD_BEEF;
        do_write("wrap", 32'h8000_0010, 0, WRAP, 4'd7, 8'hFF, -1, 2'b10);
        set_exp(0, 64'h1122_3344_5566_7788, 2'b00);
        do_read(32'h8000_0010, 0, INCR, 4'd7, 1'b0);
        wbuf[0] = 64'h1; wbuf[1] = 64'h2;
        do_write("early_wlast", 32'h8000_0300, 1, INCR, 4'd8, 8'hFF, 0, 2'b10);

        // INCR burst that walks off the end of the array
        wbuf[0] = 64'hABCD; wbuf[1] = 64'h1234;
        do_write("edge", 32'h8000_7FF8, 1, INCR, 4'd9, 8'hFF, -1, 2'b10);
        set_exp(0, 64'hABCD, 2'b00);
        set_exp(1, 64'h0, 2'b10);
        do_read(32'h8000_7FF8, 1, INCR, 4'd9, 1'b0);

        // 256-beat burst
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = (64'(i) * 64'h0101_0101_0101_0101) ^ 64'hA5A5_0000_5A5A_0000;
            set_exp(i, wbuf[i], 2'b00);
        end
        do_write("len255", 32'h8000_1000, 8'd255, INCR, 4'd10, 8'hFF, -1, 2'b00);
        do_read(32'h8000_1000, 8'd255, INCR, 4'd10, 1'b0);

        // Arbitration from a fresh reset: read first, then alternate
        reset_dut();
        reset = 1'b0;
        araddr = 32'h8000_0010; arlen = 0; arsize = 3; arburst = INCR; arid = 4'd1;
        awaddr = 32'h8000_0500; awlen = 0; awsize = 3; awburst = INCR; awid = 4'd2;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        chk("arb1_arready", arready, 1);
        chk("arb1_awready", awready, 0);
        @(posedge clock); #1;
        arvalid = 1'b0;
        chk("arb1_aw_blocked", awready, 0);
        set_exp(0, 64'h1122_3344_5566_7788, 2'b00);
        r_recv(0, 4'd1, 1'b0, lat);
        wbuf[0] = 64'h5555;
        do_write("arb1_wr", 32'h8000_0500, 0, INCR, 4'd2, 8'hFF, -1, 2'b00);
        set_exp(0, 64'h5555, 2'b00);
        do_read(32'h8000_0500, 0, INCR, 4'd3, 1'b0);
        araddr = 32'h8000_0500; arid = 4'd4; awaddr = 32'h8000_0508; awid = 4'd6;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        chk("arb2_arready", arready, 0);
        chk("arb2_awready", awready, 1);
        @(posedge clock); #1;
        awvalid = 1'b0;
        chk("arb2_ar_blocked", arready, 0);
        wbuf[0] = 64'h6666;
        begin
            logic [1:0] resp;
            logic [3:0] bid_o;
            w_phase(0, 8'hFF, -1, resp, bid_o);
            chk("arb2_bresp", resp, 0);
            chk("arb2_bid", bid_o, 6);
        end
        ar_send(32'h8000_0500, 0, INCR, 4'd4);
        r_recv(0, 4'd4, 1'b0, lat);

        // Reset in the middle of a long read
        begin
            int b = 0;
            int n = 0;
            ar_send(32'h8000_0100, 7, INCR, 4'd11);
            rready = 1'b1;
            while (b < 2 && n < 100) begin
                if (rvalid) b++;
                @(posedge clock); #1;
                n++;
            end
            chk("midrst_rvalid_before", rvalid, 1);
            chk("midrst_beat2", rdata, 64'h2);
            reset = 1'b1; arvalid = 1'b1;
            @(posedge clock); #1;
            chk("midrst_rvalid", rvalid, 0);
            chk("midrst_arready", arready, 0);
            rready = 1'b0; arvalid = 1'b0;
            @(posedge clock); #1;
            reset = 1'b0;
        end
        set_exp(0, 64'h1, 2'b00);
        ar_send(32'h8000_0108, 0, INCR, 4'd12);
        r_recv(0, 4'd12, 1'b0, lat);
        chk("post_rst_latency", lat, LAT_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
